// File: rtl/ahb_interconnect_n_if.sv
// rtl/ahb_interconnect_n_if.sv - AHB-Lite master/slave bus bundle for ahb_interconnect_n
interface ahb_interconnect_n_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 5
);
   logic [ADDR_WIDTH-1:0]            h_addr;
   logic [1:0]                       h_trans;
   logic [NUM_SLAVES-1:0]            h_sel_x;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] h_rdata_x;
   logic [NUM_SLAVES-1:0]            h_ready_x;
   logic [NUM_SLAVES-1:0]            h_resp_x;
   logic [DATA_WIDTH-1:0]            h_rdata;
   logic                             h_ready;
   logic                             h_resp;

   // Master plus slave instances on one side, interconnect on the other.
   modport master (
      output h_addr, h_trans, h_rdata_x, h_ready_x, h_resp_x,
      input  h_sel_x, h_rdata, h_ready, h_resp
   );

   modport slave (
      input  h_addr, h_trans, h_rdata_x, h_ready_x, h_resp_x,
      output h_sel_x, h_rdata, h_ready, h_resp
   );
endinterface

// File: rtl/ahb_interconnect_n.sv
// rtl/ahb_interconnect_n.sv - single-master AHB-Lite decoder, response mux and ERROR default slave
module ahb_interconnect_n #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_SLAVES  = 5,
   parameter int                    REGION_BITS = 11,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    CNT_WIDTH   = 8
) (
   input  logic                  h_clk,
   input  logic                  h_reset,
   ahb_interconnect_n_if.slave   bus,
   input  logic                  err_clr,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] err_addr
);
   // Index 16 is outside any legal slave index, so it marks the default slave.
   localparam logic [4:0] DEFAULT = 5'd16;

   typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_t;

   logic [ADDR_WIDTH-1:0] w_offset;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_hit;
   logic [NUM_SLAVES-1:0] w_sel;
   logic [4:0]            r_dp_sel;
   ds_state_t             r_state;
   ds_state_t             w_next_state;
   logic                  w_ds_ready;
   logic                  w_ds_resp;
   logic                  w_err_evt;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_ready;
   logic                  w_resp;
   logic [CNT_WIDTH-1:0]  r_err_count;
   logic [ADDR_WIDTH-1:0] r_err_addr;

   assign w_offset = bus.h_addr - BASE_ADDR;
   assign w_idx    = w_offset >> REGION_BITS;
   assign w_hit    = (bus.h_addr >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(NUM_SLAVES));

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!h_reset && w_hit && (w_idx == ADDR_WIDTH'(i)))
            w_sel[i] = 1'b1;
      end
   end

   assign bus.h_sel_x = w_sel;

   // Holding while h_ready is low keeps a wait-stated slave in charge of the response.
   always_ff @(posedge h_clk) begin
      if (h_reset)
         r_dp_sel <= DEFAULT;
      else if (w_ready)
         r_dp_sel <= w_hit ? w_idx[4:0] : DEFAULT;
   end

   // Only the owning slave's lane is looked at, so unselected X cannot leak through.
   always_comb begin
      w_rdata = '0;
      w_ready = w_ds_ready;
      w_resp  = w_ds_resp;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_dp_sel == 5'(i)) begin
            w_rdata = bus.h_rdata_x[i*DATA_WIDTH +: DATA_WIDTH];
            w_ready = bus.h_ready_x[i];
            w_resp  = bus.h_resp_x[i];
         end
      end
   end

   assign bus.h_rdata = w_rdata;
   assign bus.h_ready = w_ready;
   assign bus.h_resp  = w_resp;

   assign w_err_evt = ((r_state == DS_OK) || (r_state == DS_ERR2)) && w_ready
                      && !w_hit && bus.h_trans[1];

   always_ff @(posedge h_clk) begin
      if (h_reset)
         r_state <= DS_OK;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DS_OK:   w_next_state = w_err_evt ? DS_ERR1 : DS_OK;
         DS_ERR1: w_next_state = DS_ERR2;
         DS_ERR2: w_next_state = w_err_evt ? DS_ERR1 : DS_OK;
         default: w_next_state = DS_OK;
      endcase
   end

   always_comb begin
      w_ds_ready = 1'b1;
      w_ds_resp  = 1'b0;
      case (r_state)
         DS_ERR1: begin
            w_ds_ready = 1'b0;
            w_ds_resp  = 1'b1;
         end
         DS_ERR2: begin
            w_ds_ready = 1'b1;
            w_ds_resp  = 1'b1;
         end
         default: begin
            w_ds_ready = 1'b1;
            w_ds_resp  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge h_clk) begin
      if (h_reset) begin
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else begin
         if (w_err_evt)
            r_err_addr <= bus.h_addr;
         if (err_clr)
            r_err_count <= w_err_evt ? CNT_WIDTH'(1) : '0;
         else if (w_err_evt && (r_err_count != '1))
            r_err_count <= r_err_count + CNT_WIDTH'(1);
      end
   end

   assign err_count = r_err_count;
   assign err_addr  = r_err_addr;
endmodule

// File: tb/tb_ahb_interconnect_n.sv
// tb/tb_ahb_interconnect_n.sv - scoreboard bench for ahb_interconnect_n
module tb_ahb_interconnect_n;
   localparam logic [1:0]  ID  = 2'b00;
   localparam logic [1:0]  NS  = 2'b10;
   localparam logic [1:0]  SQ  = 2'b11;
   localparam logic [4:0]  ALL = 5'b11111;
   localparam logic [31:0] D0  = 32'h0000_A000;
   localparam logic [31:0] D1  = 32'hDEAD_BEEF;
   localparam logic [31:0] D2  = 32'h2222_2222;

   typedef struct {
      int          id;
      logic [4:0]  sel;
      logic [31:0] rdata;
      logic        ready;
      logic        resp;
      logic [7:0]  cnt;
      logic [31:0] eaddr;
      logic [1:0]  cnt2;
   } exp_t;

   logic        h_clk = 1'b0;
   logic        h_reset;
   logic        err_clr;
   logic [7:0]  err_count;
   logic [31:0] err_addr;
   logic [1:0]  err_count2;
   logic [31:0] err_addr2;
   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          vec_id = 0;

   ahb_interconnect_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(5)) bus ();
   ahb_interconnect_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(5)) bus2 ();

   assign bus2.h_addr    = bus.h_addr;
   assign bus2.h_trans   = bus.h_trans;
   assign bus2.h_rdata_x = bus.h_rdata_x;
   assign bus2.h_ready_x = bus.h_ready_x;
   assign bus2.h_resp_x  = bus.h_resp_x;

   ahb_interconnect_n #(.CNT_WIDTH(8)) dut (
      .h_clk(h_clk), .h_reset(h_reset), .bus(bus.slave),
      .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr)
   );

   ahb_interconnect_n #(.CNT_WIDTH(2)) dut2 (
      .h_clk(h_clk), .h_reset(h_reset), .bus(bus2.slave),
      .err_clr(err_clr), .err_count(err_count2), .err_addr(err_addr2)
   );

   always #5 h_clk = ~h_clk;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
      end
   endtask

   always @(negedge h_clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("h_sel_x",    e.id, 32'(bus.h_sel_x), 32'(e.sel));
         chk("h_rdata",    e.id, bus.h_rdata,      e.rdata);
         chk("h_ready",    e.id, 32'(bus.h_ready), 32'(e.ready));
         chk("h_resp",     e.id, 32'(bus.h_resp),  32'(e.resp));
         chk("err_count",  e.id, 32'(err_count),   32'(e.cnt));
         chk("err_addr",   e.id, err_addr,         e.eaddr);
         chk("err_count2", e.id, 32'(err_count2),  32'(e.cnt2));
      end
   end

   task automatic v(input logic rst, input logic [31:0] addr, input logic [1:0] trans,
                    input logic [4:0] rdy, input logic [4:0] rsp, input logic clr,
                    input logic [4:0] es, input logic [31:0] erd, input logic ery,
                    input logic ers, input logic [7:0] ec, input logic [31:0] ea,
                    input logic [1:0] ec2);
      exp_t e;
      @(posedge h_clk);
      #1;
      h_reset       = rst;
      bus.h_addr    = addr;
      bus.h_trans   = trans;
      bus.h_ready_x = rdy;
      bus.h_resp_x  = rsp;
      err_clr       = clr;
      e.id = vec_id; e.sel = es; e.rdata = erd; e.ready = ery; e.resp = ers;
      e.cnt = ec; e.eaddr = ea; e.cnt2 = ec2;
      q.push_back(e);
      vec_id++;
   endtask

   initial begin
      h_reset       = 1'b1;
      err_clr       = 1'b0;
      bus.h_addr    = 32'h0;
      bus.h_trans   = ID;
      bus.h_ready_x = ALL;
      bus.h_resp_x  = 5'b0;
      bus.h_rdata_x = {32'h4444_4444, 32'h3333_3333, D2, D1, D0};

      // rst addr trans rdy rsp clr | sel rdata ready resp cnt eaddr cnt2
      v(1, 32'h0804, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 0, 0, 0, 0);
      v(0, 32'h0804, NS, ALL,      5'b0,     0, 5'b00010, 0,  1, 0, 0, 0, 0);
      v(0, 32'h1000, NS, ALL,      5'b0,     0, 5'b00100, D1, 1, 0, 0, 0, 0);
      v(0, 32'h0000, NS, 5'b11011, 5'b0,     0, 5'b00001, D2, 0, 0, 0, 0, 0);
      v(0, 32'h0000, NS, 5'b11011, 5'b0,     0, 5'b00001, D2, 0, 0, 0, 0, 0);
      v(0, 32'h0000, NS, ALL,      5'b0,     0, 5'b00001, D2, 1, 0, 0, 0, 0);
      v(0, 32'h0000, ID, 5'b11101, 5'b00100, 0, 5'b00001, D0, 1, 0, 0, 0, 0);
      // unmapped NONSEQ: two-cycle ERROR
      v(0, 32'h3000, NS, ALL,      5'b0,     0, 5'b00000, D0, 1, 0, 0, 0, 0);
      v(0, 32'h0000, ID, ALL,      5'b0,     0, 5'b00001, 0,  0, 1, 1, 32'h3000, 1);
      v(0, 32'h0000, ID, ALL,      5'b0,     0, 5'b00001, 0,  1, 1, 1, 32'h3000, 1);
      // IDLE unmapped then back-to-back SEQs
      v(0, 32'h3000, ID, ALL,      5'b0,     0, 5'b00000, D0, 1, 0, 1, 32'h3000, 1);
      v(0, 32'h3004, SQ, ALL,      5'b0,     0, 5'b00000, 0,  1, 0, 1, 32'h3000, 1);
      v(0, 32'h3008, SQ, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 2, 32'h3004, 2);
      v(0, 32'h3008, SQ, ALL,      5'b0,     0, 5'b00000, 0,  1, 1, 2, 32'h3004, 2);
      v(0, 32'h0000, ID, ALL,      5'b0,     0, 5'b00001, 0,  0, 1, 3, 32'h3008, 3);
      v(0, 32'h0000, ID, ALL,      5'b0,     0, 5'b00001, 0,  1, 1, 3, 32'h3008, 3);
      // reset during ERR1 with count 4
      v(0, 32'h3000, NS, ALL,      5'b0,     0, 5'b00000, D0, 1, 0, 3, 32'h3008, 3);
      v(1, 32'h0804, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 4, 32'h3000, 3);
      v(1, 32'h0804, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 0, 0, 0, 0);
      // five unmapped NONSEQs, saturation of the 2-bit counter, clear on an event
      v(0, 32'h3000, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 0, 0, 0, 0);
      v(0, 32'h3004, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 1, 32'h3000, 1);
      v(0, 32'h3004, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 1, 1, 32'h3000, 1);
      v(0, 32'h3008, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 2, 32'h3004, 2);
      v(0, 32'h3008, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 1, 2, 32'h3004, 2);
      v(0, 32'h300C, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 3, 32'h3008, 3);
      v(0, 32'h300C, NS, ALL,      5'b0,     0, 5'b00000, 0,  1, 1, 3, 32'h3008, 3);
      v(0, 32'h3010, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 4, 32'h300C, 3);
      v(0, 32'h3010, NS, ALL,      5'b0,     1, 5'b00000, 0,  1, 1, 4, 32'h300C, 3);
      v(0, 32'h3014, NS, ALL,      5'b0,     0, 5'b00000, 0,  0, 1, 1, 32'h3010, 1);
      // clear without an event; err_addr untouched
      v(0, 32'h0000, ID, ALL,      5'b0,     1, 5'b00001, 0,  1, 1, 1, 32'h3010, 1);
      v(0, 32'h0000, ID, ALL,      5'b0,     0, 5'b00001, D0, 1, 0, 0, 32'h3010, 0);

      repeat (3) @(posedge h_clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
